// File: rtl/usb_fs_rx.sv
// Full-speed USB receive front end: pad synchronisation, 4x oversampled bit recovery,
// SYNC detection, NRZI decode, bit unstuffing, byte assembly, EOP/error/bus-reset flags.
module usb_fs_rx #(
    parameter int unsigned RESET_SE0_CYCLES = 120,
    parameter int unsigned SYNC_MIN_ZEROS   = 5
) (
    input  logic       clock48,
    input  logic       reset,
    input  logic       usb_d_p,
    input  logic       usb_d_n,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_active,
    output logic       rx_error,
    output logic       rx_eop,
    output logic       usb_reset
);

    localparam logic [1:0] LineSe0 = 2'b00;
    localparam logic [1:0] LineK   = 2'b01;
    localparam logic [1:0] LineJ   = 2'b10;
    localparam logic [1:0] LineSe1 = 2'b11;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StSync  = 3'd1;
    localparam logic [2:0] StData  = 3'd2;
    localparam logic [2:0] StEop   = 3'd3;
    localparam logic [2:0] StError = 3'd4;

    localparam int unsigned CntW = $clog2(RESET_SE0_CYCLES + 1);
    localparam logic [CntW-1:0] Se0Limit = CntW'(RESET_SE0_CYCLES);
    localparam logic [2:0] SyncMin = 3'(SYNC_MIN_ZEROS);

    logic            dp_meta_q, dp_sync_q, dn_meta_q, dn_sync_q;
    logic [1:0]      line;
    logic [1:0]      line_prev_q;
    logic [1:0]      phase_q, phase_d;
    logic [1:0]      last_strobe_q;
    logic            strobe;
    logic            bit_val;
    logic            is_jk;

    logic [CntW-1:0] se0_cnt_q, se0_cnt_d;
    logic            usb_reset_q, usb_reset_d;

    logic [2:0]      state_q, state_d;
    logic [2:0]      zeros_q, zeros_d;
    logic [2:0]      ones_q, ones_d;
    logic [2:0]      bits_q, bits_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            valid_q, valid_d;
    logic            error_q, error_d;
    logic            eop_q, eop_d;
    logic            active_q, active_d;
    logic            err_se0_q, err_se0_d;

    assign line = {dp_sync_q, dn_sync_q};

    // Phase restarts on every line transition, so strobe lands two cycles into the bit.
    always_comb begin
        phase_d = (line != line_prev_q) ? 2'd0 : phase_q + 2'd1;
    end

    assign strobe  = (phase_q == 2'd2);
    assign bit_val = (line_prev_q == last_strobe_q);
    assign is_jk   = (line_prev_q == LineJ) || (line_prev_q == LineK);

    always_comb begin
        se0_cnt_d = se0_cnt_q;
        if (line != LineSe0) begin
            se0_cnt_d = '0;
        end else if (se0_cnt_q != Se0Limit) begin
            se0_cnt_d = se0_cnt_q + 1'b1;
        end
        usb_reset_d = (se0_cnt_d == Se0Limit);
    end

    always_comb begin
        state_d   = state_q;
        zeros_d   = zeros_q;
        ones_d    = ones_q;
        bits_d    = bits_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        valid_d   = 1'b0;
        error_d   = 1'b0;
        eop_d     = 1'b0;
        active_d  = active_q;
        err_se0_d = err_se0_q;

        if (usb_reset_q) begin
            state_d  = StIdle;
            active_d = 1'b0;
        end else if (strobe) begin
            case (state_q)
                StIdle: begin
                    if (line_prev_q == LineK) begin
                        state_d = StSync;
                        zeros_d = 3'd1;
                    end
                end
                StSync: begin
                    if (!is_jk) begin
                        state_d = StIdle;
                    end else if (!bit_val) begin
                        if (zeros_q != 3'd7) zeros_d = zeros_q + 3'd1;
                    end else if (zeros_q >= SyncMin) begin
                        // The closing SYNC 1 already counts toward the stuffing run.
                        state_d  = StData;
                        active_d = 1'b1;
                        ones_d   = 3'd1;
                        bits_d   = 3'd0;
                    end else begin
                        state_d = StIdle;
                    end
                end
                StData: begin
                    if (line_prev_q == LineSe0) begin
                        state_d = StEop;
                        error_d = (bits_q != 3'd0);
                    end else if (line_prev_q == LineSe1) begin
                        state_d   = StError;
                        error_d   = 1'b1;
                        active_d  = 1'b0;
                        err_se0_d = 1'b0;
                    end else if (ones_q == 3'd6) begin
                        if (bit_val) begin
                            state_d   = StError;
                            error_d   = 1'b1;
                            active_d  = 1'b0;
                            err_se0_d = 1'b0;
                        end else begin
                            ones_d = 3'd0;
                        end
                    end else begin
                        shift_d = {bit_val, shift_q[7:1]};
                        ones_d  = bit_val ? ones_q + 3'd1 : 3'd0;
                        if (bits_q == 3'd7) begin
                            rx_data_d = shift_d;
                            valid_d   = 1'b1;
                            bits_d    = 3'd0;
                        end else begin
                            bits_d = bits_q + 3'd1;
                        end
                    end
                end
                StEop: begin
                    if (line_prev_q == LineSe0) begin
                        state_d  = StIdle;
                        eop_d    = 1'b1;
                        active_d = 1'b0;
                    end else begin
                        state_d   = StError;
                        error_d   = 1'b1;
                        active_d  = 1'b0;
                        err_se0_d = 1'b0;
                    end
                end
                StError: begin
                    active_d = 1'b0;
                    if (line_prev_q == LineSe0) begin
                        err_se0_d = 1'b1;
                    end else if (line_prev_q == LineJ && err_se0_q) begin
                        state_d   = StIdle;
                        err_se0_d = 1'b0;
                    end else begin
                        err_se0_d = 1'b0;
                    end
                end
                default: begin
                    state_d  = StIdle;
                    active_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock48 or posedge reset) begin
        if (reset) begin
            dp_meta_q     <= 1'b1;
            dp_sync_q     <= 1'b1;
            dn_meta_q     <= 1'b0;
            dn_sync_q     <= 1'b0;
            line_prev_q   <= LineJ;
            phase_q       <= 2'd0;
            last_strobe_q <= LineJ;
            se0_cnt_q     <= '0;
            usb_reset_q   <= 1'b0;
            state_q       <= StIdle;
            zeros_q       <= 3'd0;
            ones_q        <= 3'd0;
            bits_q        <= 3'd0;
            shift_q       <= 8'h00;
            rx_data_q     <= 8'h00;
            valid_q       <= 1'b0;
            error_q       <= 1'b0;
            eop_q         <= 1'b0;
            active_q      <= 1'b0;
            err_se0_q     <= 1'b0;
        end else begin
            dp_meta_q     <= usb_d_p;
            dp_sync_q     <= dp_meta_q;
            dn_meta_q     <= usb_d_n;
            dn_sync_q     <= dn_meta_q;
            line_prev_q   <= line;
            phase_q       <= phase_d;
            if (strobe) last_strobe_q <= line_prev_q;
            se0_cnt_q     <= se0_cnt_d;
            usb_reset_q   <= usb_reset_d;
            state_q       <= state_d;
            zeros_q       <= zeros_d;
            ones_q        <= ones_d;
            bits_q        <= bits_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            valid_q       <= valid_d;
            error_q       <= error_d;
            eop_q         <= eop_d;
            active_q      <= active_d;
            err_se0_q     <= err_se0_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = valid_q;
    assign rx_active = active_q;
    assign rx_error  = error_q;
    assign rx_eop    = eop_q;
    assign usb_reset = usb_reset_q;

endmodule

// File: tb/tb_usb_fs_rx.sv
// Directed bench for usb_fs_rx: encodes packets (NRZI + stuffing) into pad levels and
// scoreboards received bytes and pulse counts against expectations.
module tb_usb_fs_rx;

    localparam logic [1:0] LJ   = 2'b10;
    localparam logic [1:0] LK   = 2'b01;
    localparam logic [1:0] LSE0 = 2'b00;

    logic       clock48 = 1'b0;
    logic       reset   = 1'b1;
    logic       usb_d_p = 1'b1;
    logic       usb_d_n = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_active, rx_error, rx_eop, usb_reset;

    usb_fs_rx dut (
        .clock48   (clock48),
        .reset     (reset),
        .usb_d_p   (usb_d_p),
        .usb_d_n   (usb_d_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_active (rx_active),
        .rx_error  (rx_error),
        .rx_eop    (rx_eop),
        .usb_reset (usb_reset)
    );

    always #10 clock48 = ~clock48;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         got_rd = 0;
    int         n_valid = 0, n_err = 0, n_eop = 0;
    time        t_err = 0, t_eop = 0;

    logic [1:0] seq[$];
    logic       dbits[$];
    logic       cur_j;
    int         data_end;

    always @(negedge clock48) begin
        if (rx_valid) begin
            got_q.push_back(rx_data);
            n_valid++;
        end
        if (rx_error) begin
            n_err++;
            t_err = $time;
        end
        if (rx_eop) begin
            n_eop++;
            t_eop = $time;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put_dec(input logic b);
        if (!b) cur_j = ~cur_j;
        seq.push_back(cur_j ? LJ : LK);
    endtask

    task automatic add_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) dbits.push_back(b[i]);
    endtask

    // SYNC, data bits (optionally stuffed), then SE0 SE0 J J J.
    task automatic build(input bit stuff);
        int ones;
        seq.delete();
        cur_j = 1'b1;
        for (int i = 0; i < 7; i++) put_dec(1'b0);
        put_dec(1'b1);
        ones = 1;
        foreach (dbits[i]) begin
            put_dec(dbits[i]);
            ones = dbits[i] ? ones + 1 : 0;
            if (stuff && ones == 6) begin
                put_dec(1'b0);
                ones = 0;
            end
        end
        data_end = seq.size();
        seq.push_back(LSE0);
        seq.push_back(LSE0);
        for (int i = 0; i < 3; i++) seq.push_back(LJ);
        dbits.delete();
    endtask

    task automatic play(input int from, input int upto);
        for (int i = from; i < upto; i++) begin
            {usb_d_p, usb_d_n} = seq[i];
            repeat (4) @(posedge clock48);
            #1;
        end
    endtask

    task automatic idle(input int n);
        {usb_d_p, usb_d_n} = LJ;
        repeat (n) @(posedge clock48);
        #1;
    endtask

    task automatic drain(input string tag);
        logic [8:0] e;
        while (got_rd < got_q.size()) begin
            e = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
            check(tag, {23'd0, 1'b0, got_q[got_rd]}, {23'd0, e});
            got_rd++;
        end
        check({tag, "_missing"}, exp_q.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rx_data"}, {24'd0, rx_data}, 0);
        check({tag, "_rx_valid"}, {31'd0, rx_valid}, 0);
        check({tag, "_rx_active"}, {31'd0, rx_active}, 0);
        check({tag, "_rx_error"}, {31'd0, rx_error}, 0);
        check({tag, "_rx_eop"}, {31'd0, rx_eop}, 0);
        check({tag, "_usb_reset"}, {31'd0, usb_reset}, 0);
    endtask

    initial begin
        int v0, e0, p0, rise, fall;

        repeat (3) @(posedge clock48);
        #1;
        check_idle_outputs("reset");
        reset = 1'b0;
        idle(40);

        // Bus reset: SE0 long enough, then J.
        v0 = n_valid; e0 = n_err; p0 = n_eop;
        {usb_d_p, usb_d_n} = LSE0;
        rise = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clock48);
            #1;
            if (usb_reset && rise == 0) rise = i;
        end
        check("usb_reset_rise_cycle", rise, 122);
        check("usb_reset_rx_active", {31'd0, rx_active}, 0);
        {usb_d_p, usb_d_n} = LJ;
        fall = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clock48);
            #1;
            if (!usb_reset && fall == 0) fall = i;
        end
        check("usb_reset_fall_in_3", {31'd0, (fall >= 1 && fall <= 3)}, 1);
        check("usb_reset_no_pulses", (n_valid - v0) + (n_err - e0) + (n_eop - p0), 0);
        idle(40);

        // Single byte 0xA5.
        v0 = n_valid; e0 = n_err; p0 = n_eop;
        add_byte(8'hA5);
        build(1'b1);
        exp_q.push_back(8'hA5);
        play(0, 12);
        check("a5_active_mid", {31'd0, rx_active}, 1);
        play(12, seq.size());
        idle(20);
        drain("a5_byte");
        check("a5_valid_count", n_valid - v0, 1);
        check("a5_eop_count", n_eop - p0, 1);
        check("a5_err_count", n_err - e0, 0);
        check("a5_active_end", {31'd0, rx_active}, 0);

        // Stuffed bytes 0xFF, 0x3F.
        v0 = n_valid; e0 = n_err; p0 = n_eop;
        add_byte(8'hFF);
        add_byte(8'h3F);
        build(1'b1);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h3F);
        play(0, seq.size());
        idle(20);
        drain("stuff_byte");
        check("stuff_valid_count", n_valid - v0, 2);
        check("stuff_err_count", n_err - e0, 0);
        check("stuff_eop_count", n_eop - p0, 1);

        // Seven decoded ones without a stuffed zero.
        v0 = n_valid; e0 = n_err; p0 = n_eop;
        for (int i = 0; i < 7; i++) dbits.push_back(1'b1);
        build(1'b0);
        play(0, data_end);
        check("ones_active_after_err", {31'd0, rx_active}, 0);
        check("ones_err_count", n_err - e0, 1);
        play(data_end, seq.size());
        idle(20);
        check("ones_valid_count", n_valid - v0, 0);
        check("ones_eop_count", n_eop - p0, 0);
        check("ones_err_total", n_err - e0, 1);

        // Partial byte then EOP: error before eop.
        v0 = n_valid; e0 = n_err; p0 = n_eop;
        dbits.push_back(1'b1); dbits.push_back(1'b0);
        dbits.push_back(1'b1); dbits.push_back(1'b0);
        build(1'b1);
        play(0, seq.size());
        idle(20);
        check("part_err_count", n_err - e0, 1);
        check("part_eop_count", n_eop - p0, 1);
        check("part_valid_count", n_valid - v0, 0);
        check("part_err_before_eop", {31'd0, (t_err < t_eop)}, 1);

        // Reset during the second byte, then a clean packet.
        e0 = n_err; p0 = n_eop;
        add_byte(8'h12);
        add_byte(8'h34);
        build(1'b1);
        exp_q.push_back(8'h12);
        play(0, 20);
        reset = 1'b1;
        #1;
        check_idle_outputs("midreset");
        {usb_d_p, usb_d_n} = LJ;
        repeat (3) @(posedge clock48);
        #1;
        reset = 1'b0;
        idle(40);
        drain("midreset_byte");
        check("midreset_no_err", n_err - e0, 0);
        check("midreset_no_eop", n_eop - p0, 0);

        v0 = n_valid; e0 = n_err; p0 = n_eop;
        add_byte(8'h56);
        build(1'b1);
        exp_q.push_back(8'h56);
        play(0, seq.size());
        idle(20);
        drain("after_reset_byte");
        check("after_reset_valid", n_valid - v0, 1);
        check("after_reset_eop", n_eop - p0, 1);
        check("after_reset_err", n_err - e0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
